// File: rtl/mmc_cmd_seq_pkg.sv
// Purpose: shared types and constants for the MMC command sequencer and its CRC7 helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: FSM state encoding, resp_type codes, frame/turnaround/trailer lengths, CRC7 step.
package mmc_cmd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND       = 3'd1,
    ST_TURN       = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_RECV       = 3'd4,
    ST_FIN        = 3'd5
  } state_e;

  // Reserved codes behave exactly like RESP_NONE.
  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_SHORT = 2'd1,
    RESP_RSV2  = 2'd2,
    RESP_RSV3  = 2'd3
  } resp_type_e;

  localparam int unsigned FRAME_LEN  = 48;  // command and short-response frame bits
  localparam int unsigned TURN_LEN   = 2;   // released-line clocks between command and response
  localparam int unsigned TRAIL_LEN  = 8;   // trailing clocks after each sequence
  localparam int unsigned CRC_LO_BIT = 8;   // lowest frame bit covered by the CRC7
  localparam int unsigned RESP_HI    = 45;  // top frame bit captured into resp

  // x^7 + x^3 + 1
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One serial CRC7 step, MSB-first data.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/mmc_crc7.sv
// Purpose: serial CRC7 accumulator, cleared per frame, fed one bit per strobe.
// Latency: crc_o reflects a fed bit one cycle after bit_vld_i.
// Backpressure: none; accepts a bit on every cycle bit_vld_i is high.
// Ports: clk_i/rst_i (sync, active-high), clr_i (wins over bit_vld_i), bit_vld_i, bit_i, crc_o[6:0].
module mmc_crc7
  import mmc_cmd_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       bit_vld_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      crc_q <= 7'h00;
    end else if (bit_vld_i) begin
      crc_q <= crc7_next(crc_q, bit_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/mmc_cmd_seq.sv
// Purpose: MMC command sequencer: sends a 48-bit command, optionally receives a 48-bit response.
// Latency: busy one cycle after cmd_start; one clk_tick/clk_done handshake per MMC clock.
// Backpressure: every MMC clock stalls until clk_done; cmd_start ignored unless idle and not in the done cycle.
// Ports: wb_clk_i/wb_rst_i; cmd_start/cmd_index/cmd_arg/resp_type request; busy/done/timeout/crc_err/resp status;
//        clk_tick/clk_done clock-controller handshake; mmc_cmd_o/mmc_cmd_oe/mmc_cmd_i CMD line.
module mmc_cmd_seq
  import mmc_cmd_seq_pkg::*;
#(
  parameter int unsigned NCR_MAX = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  resp_type,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        crc_err,
  output logic [37:0] resp,
  output logic        clk_tick,
  input  logic        clk_done,
  output logic        mmc_cmd_o,
  output logic        mmc_cmd_oe,
  input  logic        mmc_cmd_i
);

  localparam int unsigned NCR_W = $clog2(NCR_MAX + 1);

  state_e           state_q;
  logic [5:0]       bit_cnt_q;
  logic [NCR_W-1:0] ncr_cnt_q;
  logic [39:0]      tx_sr_q;       // start, direction, index, argument; MSB goes out next
  logic             resp_short_q;
  logic             tick_wait_q;   // a tick is outstanding until clk_done
  logic             clk_tick_q;
  logic             cmd_o_q;
  logic             cmd_oe_q;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;
  logic             crc_err_q;
  logic [37:0]      resp_q;

  logic       accept;
  logic       tick_ack;
  logic       crc_clr;
  logic       crc_vld;
  logic       crc_din;
  logic [6:0] crc_val;
  logic       crc_bit;
  logic       tx_bit_d;
  logic       crc_zone;

  // The done cycle already shows IDLE, so done_q blocks a coincident start.
  assign accept   = (state_q == ST_IDLE) && cmd_start && !done_q;
  assign tick_ack = tick_wait_q && clk_done;
  assign crc_zone = (bit_cnt_q >= 6'(CRC_LO_BIT));

  // Frame bits 7..1 carry CRC bits 6..0.
  assign crc_bit  = crc_val[3'(bit_cnt_q - 6'd1)];

  always_comb begin
    tx_bit_d = 1'b1;
    if (crc_zone) begin
      tx_bit_d = tx_sr_q[39];
    end else if (bit_cnt_q != 6'd0) begin
      tx_bit_d = crc_bit;
    end
  end

  // One CRC engine: cleared on accept for TX, cleared again entering WAIT_START for RX.
  // The RX start bit is fed from WAIT_START since it is frame bit 47.
  assign crc_clr = accept || ((state_q == ST_TURN) && tick_ack && (bit_cnt_q == 6'd0));
  assign crc_din = (state_q == ST_SEND) ? tx_sr_q[39] : mmc_cmd_i;
  assign crc_vld = tick_ack &&
                   (((state_q == ST_SEND) && crc_zone) ||
                    ((state_q == ST_WAIT_START) && !mmc_cmd_i) ||
                    ((state_q == ST_RECV) && crc_zone));

  mmc_crc7 u_crc7 (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .clr_i     (crc_clr),
    .bit_vld_i (crc_vld),
    .bit_i     (crc_din),
    .crc_o     (crc_val)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      ncr_cnt_q    <= '0;
      tx_sr_q      <= '0;
      resp_short_q <= 1'b0;
      tick_wait_q  <= 1'b0;
      clk_tick_q   <= 1'b0;
      cmd_o_q      <= 1'b1;
      cmd_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      crc_err_q    <= 1'b0;
      resp_q       <= '0;
    end else begin
      done_q <= 1'b0;

      // Shared tick handshake: issue one tick, then hold until clk_done.
      // The TX bit is updated with the tick, so it is stable before the MMC edge.
      if (state_q != ST_IDLE) begin
        if (!tick_wait_q) begin
          clk_tick_q  <= 1'b1;
          tick_wait_q <= 1'b1;
          if (state_q == ST_SEND) begin
            cmd_o_q <= tx_bit_d;
          end
        end else begin
          clk_tick_q <= 1'b0;
          if (clk_done) begin
            tick_wait_q <= 1'b0;
          end
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tx_sr_q      <= {2'b01, cmd_index, cmd_arg};
            resp_short_q <= (resp_type == RESP_SHORT);
            timeout_q    <= 1'b0;
            crc_err_q    <= 1'b0;
            resp_q       <= '0;
            busy_q       <= 1'b1;
            cmd_oe_q     <= 1'b1;
            bit_cnt_q    <= 6'(FRAME_LEN - 1);
            ncr_cnt_q    <= '0;
            state_q      <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (tick_ack) begin
            if (crc_zone) begin
              tx_sr_q <= {tx_sr_q[38:0], 1'b0};
            end
            if (bit_cnt_q == 6'd0) begin
              cmd_oe_q <= 1'b0;
              cmd_o_q  <= 1'b1;
              if (resp_short_q) begin
                bit_cnt_q <= 6'(TURN_LEN - 1);
                state_q   <= ST_TURN;
              end else begin
                bit_cnt_q <= 6'(TRAIL_LEN - 1);
                state_q   <= ST_FIN;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q - 6'd1;
            end
          end
        end

        ST_TURN: begin
          if (tick_ack) begin
            if (bit_cnt_q == 6'd0) begin
              ncr_cnt_q <= '0;
              state_q   <= ST_WAIT_START;
            end else begin
              bit_cnt_q <= bit_cnt_q - 6'd1;
            end
          end
        end

        ST_WAIT_START: begin
          if (tick_ack) begin
            if (!mmc_cmd_i) begin
              bit_cnt_q <= 6'(FRAME_LEN - 2);
              state_q   <= ST_RECV;
            end else begin
              // Saturates at NCR_MAX: the timeout leaves this state on the same sample.
              ncr_cnt_q <= ncr_cnt_q + 1'b1;
              if (ncr_cnt_q == NCR_W'(NCR_MAX - 1)) begin
                timeout_q <= 1'b1;
                bit_cnt_q <= 6'(TRAIL_LEN - 1);
                state_q   <= ST_FIN;
              end
            end
          end
        end

        ST_RECV: begin
          if (tick_ack) begin
            if (crc_zone && (bit_cnt_q <= 6'(RESP_HI))) begin
              resp_q <= {resp_q[36:0], mmc_cmd_i};
            end
            if (!crc_zone && (bit_cnt_q != 6'd0) && (mmc_cmd_i != crc_bit)) begin
              crc_err_q <= 1'b1;
            end
            if (bit_cnt_q == 6'd0) begin
              if (!mmc_cmd_i) begin
                crc_err_q <= 1'b1;
              end
              bit_cnt_q <= 6'(TRAIL_LEN - 1);
              state_q   <= ST_FIN;
            end else begin
              bit_cnt_q <= bit_cnt_q - 6'd1;
            end
          end
        end

        ST_FIN: begin
          if (tick_ack) begin
            if (bit_cnt_q == 6'd0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q - 6'd1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign crc_err    = crc_err_q;
  assign resp       = resp_q;
  assign clk_tick   = clk_tick_q;
  assign mmc_cmd_o  = cmd_o_q;
  assign mmc_cmd_oe = cmd_oe_q;

endmodule

// File: tb/tb_mmc_cmd_seq.sv
// Purpose: directed self-checking bench for mmc_cmd_seq with a card/clock-controller model.
// Latency: model answers each clk_tick with clk_done after 0, or randomly 0/1/7 cycles.
// Backpressure: model holds clk_done off for the chosen delay; reply starts 5 MMC clocks after the command.
module tb_mmc_cmd_seq;

  localparam int RS = 5;  // reply start bit on the 6th released-line clock after the command

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  resp_type;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        crc_err;
  logic [37:0] resp;
  logic        clk_tick;
  logic        clk_done;
  logic        mmc_cmd_o;
  logic        mmc_cmd_oe;
  logic        mmc_cmd_i;

  int          total;
  int          bad;
  int          tick_cnt;
  int          tx_bits;
  int          post_idx;
  int          overlap_cnt;
  int          done_cnt;
  int          dly_mode;
  int          dc;
  bit          reply_en;
  logic [47:0] reply;
  logic [47:0] tx_frame;

  mmc_cmd_seq #(.NCR_MAX(64)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .cmd_start  (cmd_start),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .resp_type  (resp_type),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .crc_err    (crc_err),
    .resp       (resp),
    .clk_tick   (clk_tick),
    .clk_done   (clk_done),
    .mmc_cmd_o  (mmc_cmd_o),
    .mmc_cmd_oe (mmc_cmd_oe),
    .mmc_cmd_i  (mmc_cmd_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Clock controller plus card: captures driven bits, supplies response bits.
  initial begin : card_model
    clk_done    = 1'b0;
    mmc_cmd_i   = 1'b1;
    overlap_cnt = 0;
    forever begin
      @(posedge wb_clk_i); #1;
      if (clk_done) begin
        clk_done = 1'b0;
        if (clk_tick) overlap_cnt++;
      end else if (clk_tick) begin
        int d;
        tick_cnt++;
        d = 0;
        if (dly_mode != 0) begin
          case ($urandom_range(0, 2))
            0: d = 0;
            1: d = 1;
            default: d = 7;
          endcase
        end
        for (int i = 0; i < d; i++) begin
          @(posedge wb_clk_i); #1;
          if (clk_tick) overlap_cnt++;
        end
        if (mmc_cmd_oe) begin
          tx_frame = {tx_frame[46:0], mmc_cmd_o};
          tx_bits++;
        end else begin
          if (reply_en && post_idx >= RS && post_idx < RS + 48)
            mmc_cmd_i = reply[47 - (post_idx - RS)];
          else
            mmc_cmd_i = 1'b1;
          post_idx++;
        end
        clk_done = 1'b1;
      end
    end
  end

  initial begin : done_mon
    done_cnt = 0;
    forever begin
      @(negedge wb_clk_i);
      if (done) done_cnt++;
    end
  end

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
    @(negedge wb_clk_i);
    tx_frame  = '0;
    tx_bits   = 0;
    post_idx  = 0;
    tick_cnt  = 0;
    cmd_index = idx;
    cmd_arg   = arg;
    resp_type = rt;
    cmd_start = 1'b1;
    @(negedge wb_clk_i);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge wb_clk_i);
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", 64'(busy), 64'(0));
      end
    end
    check("done_seen", 64'(seen), 64'(1));
  endtask

  initial begin : main
    bit seen;
    total = 0; bad = 0;
    wb_rst_i = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; resp_type = '0;
    dly_mode = 0; reply_en = 1'b0; reply = '0;
    tick_cnt = 0; tx_bits = 0; post_idx = 0; tx_frame = '0;
    repeat (3) @(negedge wb_clk_i);
    check("rst_busy",    64'(busy), 64'(0));
    check("rst_done",    64'(done), 64'(0));
    check("rst_tick",    64'(clk_tick), 64'(0));
    check("rst_oe",      64'(mmc_cmd_oe), 64'(0));
    check("rst_cmd_o",   64'(mmc_cmd_o), 64'(1));
    check("rst_resp",    64'(resp), 64'(0));
    check("rst_flags",   64'({timeout, crc_err}), 64'(0));
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // CMD0, no response
    dc = done_cnt;
    start_cmd(6'd0, 32'h0, 2'd0);
    check("cmd0_busy", 64'(busy), 64'(1));
    wait_done(3000);
    // start pulse coincident with done must be dropped
    cmd_index = 6'd8; resp_type = 2'd1; cmd_start = 1'b1;
    @(negedge wb_clk_i);
    cmd_start = 1'b0;
    check("coinc_busy", 64'(busy), 64'(0));
    @(negedge wb_clk_i);
    check("coinc_tick", 64'({busy, clk_tick}), 64'(0));
    check("cmd0_frame", 64'(tx_frame), 64'h400000000095);
    check("cmd0_bits",  64'(tx_bits), 64'(48));
    check("cmd0_ticks", 64'(tick_cnt), 64'(56));
    check("cmd0_done",  64'(done_cnt - dc), 64'(1));
    check("cmd0_flags", 64'({timeout, crc_err}), 64'(0));

    // CMD8 with good short response
    reply_en = 1'b1; reply = 48'h08000001AA13;
    dc = done_cnt;
    start_cmd(6'd8, 32'h000001AA, 2'd1);
    wait_done(5000);
    @(negedge wb_clk_i);
    check("cmd8_frame", 64'(tx_frame), 64'h48000001AA87);
    check("cmd8_resp",  64'(resp), 64'h08000001AA);
    check("cmd8_crc",   64'(crc_err), 64'(0));
    check("cmd8_to",    64'(timeout), 64'(0));
    check("cmd8_ticks", 64'(tick_cnt), 64'(109));
    check("cmd8_done",  64'(done_cnt - dc), 64'(1));

    // same reply, frame bit 20 flipped
    reply = 48'h08000001AA13 ^ 48'h000000100000;
    dc = done_cnt;
    start_cmd(6'd8, 32'h000001AA, 2'd1);
    wait_done(5000);
    @(negedge wb_clk_i);
    check("bad_crc",    64'(crc_err), 64'(1));
    check("bad_resp",   64'(resp), 64'h08000011AA);
    check("bad_to",     64'(timeout), 64'(0));
    check("bad_done",   64'(done_cnt - dc), 64'(1));

    // silent card -> timeout
    reply_en = 1'b0;
    dc = done_cnt;
    start_cmd(6'd8, 32'h000001AA, 2'd1);
    wait_done(5000);
    check("to_ticks",   64'(tick_cnt), 64'(48 + 2 + 64 + 8));
    repeat (5) @(negedge wb_clk_i);
    check("to_flag",    64'(timeout), 64'(1));
    check("to_crc",     64'(crc_err), 64'(0));
    check("to_done",    64'(done_cnt - dc), 64'(1));

    // reset in the middle of SEND
    dly_mode = 1;
    start_cmd(6'd0, 32'h0, 2'd0);
    check("to_cleared", 64'(timeout), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (tx_bits >= 28) seen = 1'b1;
    end
    check("mid_reach", 64'(seen), 64'(1));
    dc = done_cnt;
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_line", 64'({mmc_cmd_oe, mmc_cmd_o, clk_tick}), 64'(3'b010));
    wb_rst_i = 1'b0;
    repeat (20) @(negedge wb_clk_i);
    check("mid_rst_nodone", 64'(done_cnt - dc), 64'(0));
    dly_mode = 0;
    start_cmd(6'd0, 32'h0, 2'd0);
    wait_done(3000);
    check("post_rst_frame", 64'(tx_frame), 64'h400000000095);
    check("post_rst_ticks", 64'(tick_cnt), 64'(56));

    // random clk_done latency
    dly_mode = 1; reply_en = 1'b1; reply = 48'h08000001AA13;
    start_cmd(6'd8, 32'h000001AA, 2'd1);
    wait_done(20000);
    check("rnd_frame",   64'(tx_frame), 64'h48000001AA87);
    check("rnd_resp",    64'(resp), 64'h08000001AA);
    check("rnd_crc",     64'(crc_err), 64'(0));
    check("rnd_ticks",   64'(tick_cnt), 64'(109));
    check("one_tick_outstanding", 64'(overlap_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmc_cmd_seq.md
MMC_CMD_SEQ -- requirements
Module: mmc_cmd_seq

Interface
REQ-001 SHALL have parameter NCR_MAX, default 64, meaning MMC clocks to wait for response start bit before timeout.
REQ-002 SHALL have ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_start  in  1  one-cycle request to issue a command.
- cmd_index  in  6  command index.
- cmd_arg  in  32  command argument.
- resp_type  in  2  0 none, 1 short (48-bit), 2/3 reserved (treated as none).
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  status: no response start bit.
- crc_err  out  1  status: response CRC7 or end-bit mismatch.
- resp  out  38  captured response bits 45..8 (index + payload).
- clk_tick  out  1  one-cycle request for one MMC clock to the clock controller.
- clk_done  in  1  one-cycle pulse on MMC clock rising edge completion.
- mmc_cmd_o  out  1  CMD line drive value.
- mmc_cmd_oe  out  1  CMD line output enable.
- mmc_cmd_i  in  1  sampled CMD line.

Function
REQ-003 SHALL implement states IDLE, SEND, TURN, WAIT_START, RECV, FIN.
REQ-004 In IDLE, cmd_start SHALL latch index/arg/resp_type, clear timeout/crc_err, assert busy next cycle, and enter SEND; cmd_start while busy SHALL be ignored.
REQ-005 SEND SHALL shift out 48 bits MSB first: 0, 1, cmd_index, cmd_arg, CRC7 over bits 47..8, 1; mmc_cmd_oe=1 throughout.
REQ-006 Each bit SHALL use one handshake: drive bit, pulse clk_tick one cycle, hold bit until clk_done, then advance; clk_tick SHALL never be asserted while a previous tick awaits clk_done.
REQ-007 After bit 0, resp_type none SHALL go to FIN; otherwise TURN with mmc_cmd_oe=0 for 2 MMC clocks, then WAIT_START.
REQ-008 WAIT_START SHALL tick the clock and sample mmc_cmd_i on each clk_done; sample 0 enters RECV (start bit counted as bit 47); NCR_MAX samples of 1 SHALL set timeout and go to FIN.
REQ-009 RECV SHALL sample 47 further bits on clk_done, shift bits 45..8 into resp, compute CRC7 over bits 47..8, and set crc_err if received CRC7 differs or end bit is 0.
REQ-010 FIN SHALL issue 8 trailing MMC clocks (mmc_cmd_oe=0), then pulse done one cycle, deassert busy the same cycle, return to IDLE.
REQ-011 Bit counter SHALL be 6-bit; NCR counter SHALL be width clog2(NCR_MAX+1) and not wrap.
REQ-012 CRC7 SHALL use polynomial x^7+x^3+1, initial value 0.
REQ-013 cmd_start coincident with done SHALL be ignored (accepted only in IDLE the cycle after).
REQ-014 resp, timeout, crc_err SHALL hold until next accepted cmd_start.

Reset
REQ-015 wb_rst_i SHALL force IDLE, busy=0, done=0, timeout=0, crc_err=0, resp=0, clk_tick=0, mmc_cmd_oe=0, mmc_cmd_o=1, counters and CRC=0, aborting any sequence with no done pulse.

Structure
REQ-016 Shared package SHALL hold state encoding, resp_type codes, frame length 48, TURN length 2, trailer length 8.
REQ-017 CRC7 SHALL be a sub-module mmc_crc7 (clear, bit-valid, data bit, 7-bit output) instanced once for TX and reused for RX.

Verification
REQ-018 CMD0 arg 0x00000000 resp none -> CMD line frame 0x400000000095, 56 clk_ticks, done, no flags.
REQ-019 CMD8 arg 0x000001AA resp short, model replies 0x08000001AA13 after 5 clocks -> tx frame 0x48000001AA87, resp=0x08000001AA, crc_err=0.
REQ-020 Same as REQ-019 with reply bit 20 flipped -> crc_err=1, done pulses.
REQ-021 resp short, mmc_cmd_i held 1 -> timeout=1 after exactly NCR_MAX WAIT_START ticks, then 8 trailer ticks, done.
REQ-022 wb_rst_i mid-SEND (bit 20) -> next cycle IDLE, oe=0, no done; new CMD0 completes correctly.
REQ-023 clk_done delayed 0/1/7 cycles randomly -> frames identical, at most one outstanding tick.
